// File: rtl/exc_collect.sv
// exc_collect: MEM-stage exception collector for the CP0 register block.
// Merges per-stage exception flags with synchronised hardware interrupts,
// picks one event by fixed priority and registers exccode/pc/in_delay
// towards CP0. After any issued exception or eret, new events are masked
// for SHADOW_CYCLES cycles while the pipeline flush completes.
//
// Optional feature macro: EXC_COLLECT_BADVADDR_EN
//   defined   : badvaddr_o captures the faulting address on address errors
//   undefined : badvaddr_o is tied to zero and mem_addr is ignored
//
// Shadow FSM states:
//   state    | meaning
//   S_IDLE   | events accepted; counter is zero
//   S_SHADOW | flush in progress; counter counts down, new events masked

module exc_collect #(
  parameter int SHADOW_CYCLES = 2,  // 1..7
  parameter int INT_SYNC      = 2   // 2 or 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_raw,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay,
  input  logic        exc_adel_if,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic        exc_adel_d,
  input  logic        exc_ades_d,
  input  logic        is_eret,
  input  logic [31:0] mem_addr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  output logic [4:0]  exccode_o,
  output logic [31:0] pc_o,
  output logic        in_delay_o,
  output logic [5:0]  int_sync_o,
  output logic [31:0] badvaddr_o
);

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;

  localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_SHADOW
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic [5:0]  sync_q [INT_SYNC];

  logic [31:0] st_eff;
  logic [31:0] ca_eff;
  logic [7:0]  ip_eff;
  logic        int_pend;
  logic        accept;

  logic [4:0]  exccode_d, exccode_q;
  logic [31:0] pc_d, pc_q;
  logic        in_delay_d, in_delay_q;

  // Interrupt synchroniser chain; the last stage is what CP0 and selection see.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < INT_SYNC; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= int_raw;
      for (int i = 1; i < INT_SYNC; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign int_sync_o = sync_q[INT_SYNC-1];

  // An mtc0 in WB must be visible to the interrupt check in the same cycle,
  // otherwise an enable written this cycle would be missed for one instruction.
  assign st_eff = (cp0_we && (cp0_waddr == ADDR_STATUS)) ? cp0_wdata : cp0_status;
  assign ca_eff = (cp0_we && (cp0_waddr == ADDR_CAUSE))  ? cp0_wdata : cp0_cause;

  // Hardware lines come from the synchroniser, software lines from cause.
  assign ip_eff   = {int_sync_o, ca_eff[9:8]} & st_eff[15:8];
  assign int_pend = st_eff[0] & ~st_eff[1] & (|ip_eff);

  assign accept = mem_valid & (state_q == S_IDLE);

  // Fixed-priority selection; lower-priority flags are dropped since the
  // instruction is flushed anyway.
  always_comb begin
    exccode_d = EXC_NONE;
    if (accept) begin
      if (int_pend)         exccode_d = EXC_INT;
      else if (exc_adel_if) exccode_d = EXC_ADEL;
      else if (exc_ri)      exccode_d = EXC_RI;
      else if (exc_ov)      exccode_d = EXC_OV;
      else if (exc_sys)     exccode_d = EXC_SYS;
      else if (exc_bp)      exccode_d = EXC_BP;
      else if (exc_adel_d)  exccode_d = EXC_ADEL;
      else if (exc_ades_d)  exccode_d = EXC_ADES;
      else if (is_eret)     exccode_d = EXC_ERET;
    end
  end

  // pc/in_delay only move when something is actually reported.
  always_comb begin
    pc_d       = pc_q;
    in_delay_d = in_delay_q;
    if (exccode_d != EXC_NONE) begin
      pc_d       = mem_pc;
      in_delay_d = mem_in_delay;
    end
  end

  // Output registers towards CP0.
  always_ff @(posedge clk) begin
    if (rst) begin
      exccode_q  <= EXC_NONE;
      pc_q       <= '0;
      in_delay_q <= 1'b0;
    end else begin
      exccode_q  <= exccode_d;
      pc_q       <= pc_d;
      in_delay_q <= in_delay_d;
    end
  end

  assign exccode_o  = exccode_q;
  assign pc_o       = pc_q;
  assign in_delay_o = in_delay_q;

  // Shadow FSM state and countdown register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow FSM next state: load on issue, count down, release at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (exccode_d != EXC_NONE) begin
          state_d = S_SHADOW;
          cnt_d   = SHADOW_LOAD;
        end
      end
      S_SHADOW: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef EXC_COLLECT_BADVADDR_EN
  logic [31:0] badvaddr_d, badvaddr_q;

  // A code of 04 with the fetch flag set can only come from the fetch error,
  // whose faulting address is the PC itself.
  always_comb begin
    badvaddr_d = badvaddr_q;
    if ((exccode_d == EXC_ADEL) || (exccode_d == EXC_ADES)) begin
      badvaddr_d = ((exccode_d == EXC_ADEL) && exc_adel_if) ? mem_pc : mem_addr;
    end
  end

  // Faulting address register, same latency as exccode_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
    end
  end

  assign badvaddr_o = badvaddr_q;

  logic unused_bits;
  assign unused_bits = ^{st_eff[31:16], st_eff[7:2], ca_eff[31:10], ca_eff[7:0]};
`else
  assign badvaddr_o = '0;

  logic unused_bits;
  assign unused_bits = ^{st_eff[31:16], st_eff[7:2], ca_eff[31:10], ca_eff[7:0],
                         mem_addr};
`endif

endmodule
